// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial W-bit adder: one shared fulladd4 walks the operands LSB nibble first.
// Optional subtract mode (A + ~B + 1) when NIBBLE_SUB_EN is defined.

module fulladd4 (
   output logic [3:0] s,
   output logic       cout,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       Cin
);
   assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, Cin};
endmodule

module nibble_serial_adder_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 cin,
`ifdef NIBBLE_SUB_EN
   input  logic                 sub,
`endif
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 cout
);
   localparam int W  = 4*NIBBLES;
   localparam int CW = $clog2(NIBBLES);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, nstate;
   logic [W-1:0]    a_r, b_r;
   logic            carry;
   logic [CW-1:0]   cnt;
   logic [3:0]      fa_s;
   logic            fa_c;
   logic            last;

   fulladd4 u_fa (
      .s   (fa_s),
      .cout(fa_c),
      .a   (a_r[4*cnt +: 4]),
      .b   (b_r[4*cnt +: 4]),
      .Cin (carry)
   );

   assign last = (cnt == CW'(NIBBLES-1));
   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (start) nstate = RUN;
         RUN:     if (last)  nstate = DONE;
         DONE:    nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r   <= '0;
         b_r   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               a_r <= a;
               sum <= '0;
               cnt <= '0;
`ifdef NIBBLE_SUB_EN
               // subtract: invert B once at capture and force the initial carry
               b_r   <= sub ? ~b : b;
               carry <= sub ? 1'b1 : cin;
`else
               b_r   <= b;
               carry <= cin;
`endif
            end
            RUN: begin
               sum[4*cnt +: 4] <= fa_s;
               carry           <= fa_c;
               cnt             <= cnt + CW'(1);
               if (last) cout <= fa_c;
            end
            default: ;
         endcase
      end
   end
endmodule
